// File: rtl/xtea_stream_adapter.sv
// XTEA stream adapter: packs eight input words into the core's data/key
// operands, starts the core, and streams the 128-bit result back out.
module xtea_stream_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_mode,
  output logic         core_start,
  output logic         core_configuration,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         error
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  localparam logic [15:0] WdLast = 16'(TIMEOUT_CYCLES - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_widx;
  logic [1:0]   r_ridx;
  logic [15:0]  r_wdog;
  logic [127:0] r_data;
  logic [127:0] r_key;
  logic [127:0] r_result;
  logic         r_cfg;
  logic         r_busy;
  logic         r_error;
  logic         w_in_hs;
  logic         w_out_hs;
  logic         w_timeout;
  logic [6:0]   w_wofs;
  logic [6:0]   w_rofs;

  // Slot 0 lands in the most significant word: offset = (3 - idx) * 32.
  assign w_wofs = {~r_widx[1:0], 5'b0};
  assign w_rofs = {~r_ridx, 5'b0};
  assign w_timeout = (r_wdog == WdLast);

  always_comb begin
    w_state_nxt = r_state;
    w_in_hs     = 1'b0;
    w_out_hs    = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_in_hs = in_valid;
        if (in_valid && (r_widx == 3'd7)) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_ready) begin
          w_state_nxt = S_DRAIN;
        end else if (w_timeout) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DRAIN: begin
        w_out_hs = out_ready;
        if (out_ready && (r_ridx == 2'd3)) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_widx   <= '0;
      r_ridx   <= '0;
      r_wdog   <= '0;
      r_data   <= '0;
      r_key    <= '0;
      r_result <= '0;
      r_cfg    <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_in_hs) begin
            if (r_widx[2]) begin
              r_key[w_wofs +: 32] <= in_data;
            end else begin
              r_data[w_wofs +: 32] <= in_data;
            end
            if (r_widx == 3'd0) begin
              r_cfg   <= in_mode;
              r_busy  <= 1'b1;
              r_error <= 1'b0;
            end
            r_widx <= r_widx + 3'd1;
          end
        end
        S_START: begin
          r_wdog <= '0;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle beats the abort.
          if (core_ready) begin
            r_result <= core_result;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        S_DRAIN: begin
          if (w_out_hs) begin
            r_ridx <= r_ridx + 2'd1;
            if (r_ridx == 2'd3) begin
              r_busy <= 1'b0;
            end
          end
        end
        default: begin
          r_widx <= '0;
        end
      endcase
    end
  end

  assign in_ready           = (r_state == S_LOAD);
  assign core_start         = (r_state == S_START);
  assign out_valid          = (r_state == S_DRAIN);
  assign out_last           = (r_state == S_DRAIN) && (r_ridx == 2'd3);
  assign out_data           = r_result[w_rofs +: 32];
  assign core_configuration = r_cfg;
  assign core_data          = r_data;
  assign core_key           = r_key;
  assign busy               = r_busy;
  assign error              = r_error;

endmodule

// File: tb/tb_xtea_stream_adapter.sv
// Directed bench for xtea_stream_adapter: dut_a uses the default
// watchdog, dut_b a 16-cycle watchdog; both share the input stimulus.
module tb_xtea_stream_adapter;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_mode = 1'b0;
  logic         core_ready = 1'b0;
  logic [127:0] core_result = '0;
  logic         out_ready = 1'b0;

  logic         a_in_ready, a_core_start, a_core_cfg, a_out_valid;
  logic         a_out_last, a_busy, a_error;
  logic [127:0] a_core_data, a_core_key;
  logic [31:0]  a_out_data;
  logic         b_in_ready, b_core_start, b_core_cfg, b_out_valid;
  logic         b_out_last, b_busy, b_error;
  logic [127:0] b_core_data, b_core_key;
  logic [31:0]  b_out_data;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] BLK1 = {
    128'h0123456789ABCDEFFEDCBA9876543210,
    128'h00112233445566778899AABBCCDDEEFF};
  localparam logic [255:0] BLK2 = {
    128'h10000000100000011000000210000003,
    128'h10000004100000051000000610000007};
  localparam logic [255:0] BLK3 = {
    128'hC0DE0000C0DE1111C0DE2222C0DE3333,
    128'hFACE4444FACE5555FACE6666FACE7777};
  localparam logic [127:0] R1 = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;
  localparam logic [127:0] R2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] R3 = 128'h0BADF00D_12345678_9ABCDEF0_FFFF0000;

  xtea_stream_adapter dut_a (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .core_start(a_core_start), .core_configuration(a_core_cfg),
    .core_data(a_core_data), .core_key(a_core_key),
    .core_ready(core_ready), .core_result(core_result),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_last(a_out_last),
    .busy(a_busy), .error(a_error)
  );

  xtea_stream_adapter #(.TIMEOUT_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .core_start(b_core_start), .core_configuration(b_core_cfg),
    .core_data(b_core_data), .core_key(b_core_key),
    .core_ready(core_ready), .core_result(core_result),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_last(b_out_last),
    .busy(b_busy), .error(b_error)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "bench timeout");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    core_ready = 1'b0;
    out_ready = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  // Offers the 8 words of blk; returns with the adapter in START.
  task automatic load_block(input logic [255:0] blk, input logic mode,
                            input bit gaps, input bit use_b,
                            output int got);
    int n;
    logic rdy;
    n = 0;
    got = 0;
    while (got < 8 && n < 64) begin
      in_valid = gaps ? n[0] : 1'b1;
      in_data = blk[255 - 32*got -: 32];
      in_mode = (got == 0) ? mode : ~mode;
      rdy = use_b ? b_in_ready : a_in_ready;
      if (in_valid && rdy) got++;
      tick;
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 ||
        a_core_start !== 1'b0 || a_out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b ov=%b st=%b last=%b exp 1000",
               a_in_ready, a_out_valid, a_core_start, a_out_last);
    end
    checks++;
    if (a_core_data !== '0 || a_core_key !== '0 || a_out_data !== '0) begin
      errors++;
      $display("FAIL reset_regs got data=%h key=%h out=%h exp 0",
               a_core_data, a_core_key, a_out_data);
    end
    checks++;
    if (a_busy !== 1'b0 || a_error !== 1'b0 || a_core_cfg !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b err=%b cfg=%b exp 000",
               a_busy, a_error, a_core_cfg);
    end
  endtask

  task automatic test_basic_load;
    int got;
    do_reset;
    core_ready = 1'b1;
    load_block(BLK1, 1'b1, 1'b0, 1'b0, got);
    checks++;
    if (a_core_data !== 128'h0123456789ABCDEFFEDCBA9876543210) begin
      errors++;
      $display("FAIL basic_data got %h exp %h", a_core_data,
               128'h0123456789ABCDEFFEDCBA9876543210);
    end
    checks++;
    if (a_core_key !== 128'h00112233445566778899AABBCCDDEEFF) begin
      errors++;
      $display("FAIL basic_key got %h exp %h", a_core_key,
               128'h00112233445566778899AABBCCDDEEFF);
    end
    checks++;
    if (a_core_cfg !== 1'b1 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_cfg got cfg=%b busy=%b exp 11",
               a_core_cfg, a_busy);
    end
    checks++;
    if (a_core_start !== 1'b1 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_start_on got st=%b rdy=%b exp 10",
               a_core_start, a_in_ready);
    end
    core_ready = 1'b0;
    tick;
    checks++;
    if (a_core_start !== 1'b0 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_start_off got st=%b ov=%b exp 00",
               a_core_start, a_out_valid);
    end
  endtask

  task automatic test_drain_backpressure;
    int got;
    logic [127:0] r;
    logic [31:0] w;
    do_reset;
    load_block(BLK1, 1'b1, 1'b0, 1'b0, got);
    tick;
    repeat (39) tick;
    core_ready = 1'b1;
    core_result = R1;
    tick;
    core_ready = 1'b0;
    core_result = '0;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 32'hA5A5A5A5 ||
          a_out_last !== 1'b0) begin
        errors++;
        $display("FAIL drain_stall%0d got ov=%b d=%h last=%b exp 1 a5a5a5a5 0",
                 s, a_out_valid, a_out_data, a_out_last);
      end
      tick;
    end
    out_ready = 1'b1;
    r = R1;
    for (int k = 0; k < 4; k++) begin
      w = r[127 - 32*k -: 32];
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== w ||
          a_out_last !== (k == 3)) begin
        errors++;
        $display("FAIL drain_word%0d got ov=%b d=%h last=%b exp 1 %h %b",
                 k, a_out_valid, a_out_data, a_out_last, w, k == 3);
      end
      checks++;
      if (a_busy !== 1'b1 ||
          a_core_data !== 128'h0123456789ABCDEFFEDCBA9876543210) begin
        errors++;
        $display("FAIL drain_hold%0d got busy=%b data=%h", k, a_busy,
                 a_core_data);
      end
      tick;
    end
    out_ready = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_done got ov=%b busy=%b rdy=%b exp 001",
               a_out_valid, a_busy, a_in_ready);
    end
  endtask

  task automatic test_input_gaps;
    int got;
    int bad;
    logic [127:0] r;
    logic [31:0] w;
    do_reset;
    load_block(BLK2, 1'b0, 1'b1, 1'b0, got);
    checks++;
    if (got !== 8 || a_core_start !== 1'b1) begin
      errors++;
      $display("FAIL gaps_count got %0d st=%b exp 8 1", got, a_core_start);
    end
    checks++;
    if (a_core_data !== BLK2[255:128] || a_core_key !== BLK2[127:0] ||
        a_core_cfg !== 1'b0) begin
      errors++;
      $display("FAIL gaps_block got %h %h cfg=%b exp %h %h 0",
               a_core_data, a_core_key, a_core_cfg, BLK2[255:128],
               BLK2[127:0]);
    end
    in_valid = 1'b1;
    in_data = 32'hBAD0BAD0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_in_ready) bad++;
      tick;
    end
    core_ready = 1'b1;
    core_result = R2;
    if (a_in_ready) bad++;
    tick;
    core_ready = 1'b0;
    out_ready = 1'b1;
    r = R2;
    for (int k = 0; k < 4; k++) begin
      w = r[127 - 32*k -: 32];
      if (a_in_ready) bad++;
      checks++;
      if (a_out_data !== w) begin
        errors++;
        $display("FAIL gaps_word%0d got %h exp %h", k, a_out_data, w);
      end
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gaps_in_ready got %0d high cycles exp 0", bad);
    end
    checks++;
    if (a_core_data !== BLK2[255:128] || a_core_key !== BLK2[127:0] ||
        a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL gaps_no_consume got %h %h busy=%b rdy=%b",
               a_core_data, a_core_key, a_busy, a_in_ready);
    end
  endtask

  task automatic test_timeout;
    int got;
    int early;
    int ov;
    do_reset;
    load_block(BLK1, 1'b1, 1'b0, 1'b1, got);
    tick;
    early = 0;
    ov = 0;
    for (int i = 1; i < 16; i++) begin
      tick;
      if (b_error) early++;
      if (b_out_valid) ov++;
    end
    tick;
    checks++;
    if (early !== 0 || b_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge got early=%0d err=%b exp 0 1",
               early, b_error);
    end
    checks++;
    if (b_busy !== 1'b0 || b_in_ready !== 1'b1 || ov !== 0 ||
        b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state got busy=%b rdy=%b ov=%0d/%b exp 0 1 0/0",
               b_busy, b_in_ready, ov, b_out_valid);
    end
    tick;
    checks++;
    if (b_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b exp 1", b_error);
    end
    in_valid = 1'b1;
    in_data = 32'h55AA55AA;
    in_mode = 1'b0;
    tick;
    in_valid = 1'b0;
    checks++;
    if (b_error !== 1'b0 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear got err=%b busy=%b exp 0 1",
               b_error, b_busy);
    end
  endtask

  task automatic test_reset_midload;
    int got;
    int st;
    in_mode = 1'b1;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 32'hDEAD0000 + i;
      in_mode = (i == 0);
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_core_cfg !== 1'b1) begin
      errors++;
      $display("FAIL midload_pre got busy=%b cfg=%b exp 1 1",
               a_busy, a_core_cfg);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (a_core_data !== '0 || a_core_key !== '0 || a_busy !== 1'b0 ||
        a_core_cfg !== 1'b0 || a_in_ready !== 1'b1 || a_error !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset got %h %h busy=%b cfg=%b rdy=%b err=%b",
               a_core_data, a_core_key, a_busy, a_core_cfg, a_in_ready,
               a_error);
    end
    st = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (a_core_start) st++;
    end
    load_block(BLK3, 1'b1, 1'b0, 1'b0, got);
    checks++;
    if (st !== 0 || a_core_start !== 1'b1) begin
      errors++;
      $display("FAIL midload_start got stray=%0d st=%b exp 0 1",
               st, a_core_start);
    end
    checks++;
    if (a_core_data !== BLK3[255:128] || a_core_key !== BLK3[127:0] ||
        a_core_cfg !== 1'b1) begin
      errors++;
      $display("FAIL midload_block got %h %h cfg=%b exp %h %h 1",
               a_core_data, a_core_key, a_core_cfg, BLK3[255:128],
               BLK3[127:0]);
    end
  endtask

  task automatic test_ready_on_timeout;
    int got;
    logic [127:0] r;
    logic [31:0] w;
    do_reset;
    load_block(BLK2, 1'b1, 1'b0, 1'b1, got);
    tick;
    repeat (15) tick;
    core_ready = 1'b1;
    core_result = R3;
    tick;
    core_ready = 1'b0;
    checks++;
    if (b_error !== 1'b0 || b_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL race_win got err=%b ov=%b exp 0 1", b_error, b_out_valid);
    end
    out_ready = 1'b1;
    r = R3;
    for (int k = 0; k < 4; k++) begin
      w = r[127 - 32*k -: 32];
      checks++;
      if (b_out_data !== w || b_out_last !== (k == 3)) begin
        errors++;
        $display("FAIL race_word%0d got %h last=%b exp %h %b",
                 k, b_out_data, b_out_last, w, k == 3);
      end
      tick;
    end
    out_ready = 1'b0;
    checks++;
    if (b_error !== 1'b0 || b_busy !== 1'b0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL race_done got err=%b busy=%b rdy=%b exp 0 0 1",
               b_error, b_busy, b_in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_basic_load;
    test_drain_backpressure;
    test_input_gaps;
    test_timeout;
    test_reset_midload;
    test_ready_on_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xtea_stream_adapter.md
# xtea_stream_adapter

Front-end stage that feeds the XTEA crypto core and collects its result. It accepts eight 32-bit words (4 data, 4 key) on a valid/ready stream and assembles them into the 128-bit `data_i`/`key` operands. It then issues a single `start` to the core, captures the 128-bit result on the core's `ready` pulse, and streams it back out as four 32-bit words. A watchdog aborts the operation if the core never answers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: maximum cycles spent waiting for `core_ready` before abort; legal range 1..65535.

Ports:
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  adapter can accept a word.
- `in_data`  in  32  input word.
- `in_mode`  in  1  1 = encrypt, 0 = decrypt; sampled only with word 0.
- `core_start`  out  1  one-cycle start pulse to core.
- `core_configuration`  out  1  mode to core; held stable for the whole operation.
- `core_data`  out  128  assembled data block.
- `core_key`  out  128  assembled key.
- `core_ready`  in  1  core result-valid pulse.
- `core_result`  in  128  core output, valid while `core_ready` = 1.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts word.
- `out_data`  out  32  output word.
- `out_last`  out  1  marks the 4th output word.
- `busy`  out  1  high from word 0 accepted until last output word accepted.
- `error`  out  1  sticky timeout flag.

## Operation
- States: LOAD, START, WAIT_CORE, DRAIN.
- LOAD:
  - `in_ready` = 1.
  - Each handshake (`in_valid` & `in_ready`) stores `in_data` into slot `widx`, then `widx` increments (3-bit counter).
  - Slots 0–3 map to `core_data` MSW first: slot 0 → [127:96], slot 3 → [31:0]. Slots 4–7 map to `core_key` in the same order.
  - On the slot-0 handshake: latch `in_mode` into `core_configuration`, set `busy`, clear `error`.
  - On the slot-7 handshake: go to START and wrap `widx` to 0.
- START: `core_start` = 1 for exactly this one cycle. Clear the watchdog counter (16-bit). Go to WAIT_CORE.
- WAIT_CORE:
  - `in_ready` = 0.
  - If `core_ready` = 1: capture `core_result` into the result register, go to DRAIN.
  - Else, if watchdog = `TIMEOUT_CYCLES`−1: set `error`, clear `busy`, go to LOAD.
  - Else: increment the watchdog.
  - If `core_ready` and the timeout condition occur in the same cycle, `core_ready` wins and no error is raised.
- DRAIN:
  - `out_valid` = 1.
  - `out_data` = result word `ridx`, MSW first.
  - `out_last` = 1 when `ridx` = 3.
  - Each handshake increments `ridx`. After word 3 is accepted: clear `busy`, go to LOAD.
  - `out_data` and `out_last` stay stable while `out_valid` & !`out_ready`.
- `core_data`, `core_key` and `core_configuration` are registers and change only on LOAD handshakes. They therefore stay stable through START, WAIT_CORE and DRAIN, as the core requires.
- `core_ready` pulses outside WAIT_CORE are ignored.
- `in_mode` on words 1–7 is ignored.

## Timing
- Reset values, in effect after the reset edge:
  - State LOAD; `widx`, `ridx` and watchdog all 0.
  - `in_ready` = 1.
  - All other outputs 0, including `core_data`, `core_key` and the result register.
- Reset asserted mid-operation discards partial words and any pending result, and returns to LOAD on that edge. No `core_start` is emitted afterwards. The core shares `reset` and aborts too.
- `in_ready`, `out_valid`, `out_last` and `core_start` are decoded from state only; there is no combinational path from inputs to outputs.
- Latencies:
  - Slot-7 handshake at edge N → `core_start` high during cycle N+1 → state WAIT_CORE at edge N+2.
  - `core_ready` sampled at edge M → `out_valid` high from M.
  - With `out_ready` = 1 continuously, the 4 output words take 4 cycles, and `in_ready` returns 1 after edge M+4.
- Minimum turnaround is 8 (load) + 1 (start) + core latency + 4 (drain) cycles. Back-to-back blocks are allowed with no idle cycle.
- Timeout: `error` rises `TIMEOUT_CYCLES` cycles after entering WAIT_CORE.

## Test plan
- **Basic load:**
  - Stimulus: load `in_mode` = 1 and words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210, then key words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, with `in_valid` held high.
  - Required: `core_data` = 128'h0123456789ABCDEFFEDCBA9876543210 and `core_key` = 128'h00112233445566778899AABBCCDDEEFF. `core_configuration` = 1. `core_start` is high for exactly one cycle, the cycle after the 8th handshake.
- **Drain with backpressure:**
  - Stimulus: core model pulses `core_ready` 40 cycles after start, with `core_result` = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D. Hold `out_ready` low for 3 cycles, then high.
  - Required: output words appear in order A5A5A5A5, 5A5A5A5A, DEADBEEF, CAFEF00D. `out_data` is stable during the stall. `out_last` is high only on CAFEF00D. `busy` falls after that handshake.
- **Input gaps:**
  - Stimulus: toggle `in_valid` every other cycle during load, then drive `in_valid` high during WAIT_CORE and DRAIN.
  - Required: exactly 8 words are captured. `in_ready` = 0 throughout WAIT_CORE and DRAIN, and no word is consumed there.
- **Timeout abort:**
  - Stimulus: `TIMEOUT_CYCLES` = 16; core never answers.
  - Required: `error` = 1 exactly 16 cycles after entering WAIT_CORE, `busy` = 0, `in_ready` = 1, `out_valid` never asserts. `error` clears on the next slot-0 handshake.
- **Reset mid-load:**
  - Stimulus: assert `reset` for 1 cycle after 5 words are accepted.
  - Required: all outputs return to their reset values. The next 8 words form a fresh block, with slot 0 taken from the first post-reset word.
- **Ready on the timeout cycle:**
  - Stimulus: `TIMEOUT_CYCLES` = 16, `core_ready` pulsed in the 16th WAIT_CORE cycle.
  - Required: `error` stays 0 and the result drains normally.
